// File: rtl/edge_evt_pkg.sv
// Shared types and default sizing for the edge event tracker.
package edge_evt_pkg;

    typedef enum logic {EVT_FALL = 1'b0, EVT_RISE = 1'b1} edge_kind_e;

    localparam int unsigned TS_W_DEF  = 16;
    localparam int unsigned DEPTH_DEF = 4;
    localparam int unsigned CNT_W_DEF = 8;

endpackage

// File: rtl/edge_evt_fifo.sv
// Synchronous FIFO with clear; occupancy is tracked separately from the pointers.
module edge_evt_fifo #(
    parameter int unsigned WIDTH = 17,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           din_i,
    output logic [WIDTH-1:0]           dout_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     level_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] cnt_q, cnt_d;
    logic             push_ok;
    logic             pop_ok;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == LVL_W'(DEPTH));
    assign level_o = cnt_q;
    // Head reads as zero when empty so the port never shows stale data.
    assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        pop_ok   = pop_i & ~empty_o;
        push_ok  = push_i & (~full_o | pop_ok);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push_ok && !pop_ok)      cnt_d = cnt_q + LVL_W'(1);
            else if (!push_ok && pop_ok) cnt_d = cnt_q - LVL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && push_ok && !clr_i) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/edge_event_tracker.sv
// Edge detector with timestamped event queue and saturating status counters.
module edge_event_tracker
    import edge_evt_pkg::*;
#(
    parameter int unsigned TS_W  = TS_W_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en_i,
    input  logic                      sample_i,
    input  logic                      sample_prev_i,
    input  logic                      clr_i,
    output logic                      evt_valid_o,
    input  logic                      evt_ready_i,
    output logic                      evt_rise_o,
    output logic [TS_W-1:0]           evt_ts_o,
    output logic [$clog2(DEPTH):0]    level_o,
    output logic [CNT_W-1:0]          rise_cnt_o,
    output logic [CNT_W-1:0]          fall_cnt_o,
    output logic [CNT_W-1:0]          drop_cnt_o,
    output logic                      overflow_o
);

    localparam int unsigned ENTRY_W = TS_W + 1;

    logic [TS_W-1:0]    ts_q, ts_d;
    logic [CNT_W-1:0]   rise_cnt_q, rise_cnt_d;
    logic [CNT_W-1:0]   fall_cnt_q, fall_cnt_d;
    logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
    logic               ovf_q, ovf_d;
    logic               rise_det, fall_det, edge_det;
    logic               pop_req, drop;
    logic               fifo_full, fifo_empty;
    edge_kind_e         kind;
    logic [ENTRY_W-1:0] fifo_din, fifo_dout;

    always_comb begin
        // A clear in the same cycle discards the edge entirely.
        rise_det = en_i & ~clr_i & sample_i & ~sample_prev_i;
        fall_det = en_i & ~clr_i & ~sample_i & sample_prev_i;
        edge_det = rise_det | fall_det;
        kind     = rise_det ? EVT_RISE : EVT_FALL;
        fifo_din = {kind, ts_q};
        pop_req  = ~fifo_empty & evt_ready_i;
        drop     = edge_det & fifo_full & ~pop_req;

        ts_d       = ts_q;
        rise_cnt_d = rise_cnt_q;
        fall_cnt_d = fall_cnt_q;
        drop_cnt_d = drop_cnt_q;
        ovf_d      = ovf_q;
        if (clr_i) begin
            ts_d       = '0;
            rise_cnt_d = '0;
            fall_cnt_d = '0;
            drop_cnt_d = '0;
            ovf_d      = 1'b0;
        end else begin
            if (en_i) ts_d = ts_q + TS_W'(1);
            if (rise_det && rise_cnt_q != {CNT_W{1'b1}}) rise_cnt_d = rise_cnt_q + CNT_W'(1);
            if (fall_det && fall_cnt_q != {CNT_W{1'b1}}) fall_cnt_d = fall_cnt_q + CNT_W'(1);
            if (drop) begin
                ovf_d = 1'b1;
                if (drop_cnt_q != {CNT_W{1'b1}}) drop_cnt_d = drop_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ts_q       <= '0;
            rise_cnt_q <= '0;
            fall_cnt_q <= '0;
            drop_cnt_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            ts_q       <= ts_d;
            rise_cnt_q <= rise_cnt_d;
            fall_cnt_q <= fall_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            ovf_q      <= ovf_d;
        end
    end

    edge_evt_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (clr_i),
        .push_i  (edge_det),
        .pop_i   (pop_req),
        .din_i   (fifo_din),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (level_o)
    );

    assign evt_valid_o = ~fifo_empty;
    assign evt_rise_o  = fifo_dout[TS_W];
    assign evt_ts_o    = fifo_dout[TS_W-1:0];
    assign rise_cnt_o  = rise_cnt_q;
    assign fall_cnt_o  = fall_cnt_q;
    assign drop_cnt_o  = drop_cnt_q;
    assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_edge_event_tracker.sv
// Directed table-driven bench for edge_event_tracker (TS_W=16, DEPTH=4, CNT_W=8).
module tb_edge_event_tracker;

    typedef struct packed {
        logic        valid;
        logic        rise;
        logic [15:0] ts;
        logic [2:0]  level;
        logic [7:0]  rc;
        logic [7:0]  fc;
        logic [7:0]  dc;
        logic        ov;
    } out_t;

    typedef struct {
        logic en, s, p, clr, rdy;
        out_t exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n, en, smp, smp_prev, clr, rdy;
    logic        valid, rise;
    logic [15:0] ts;
    logic [2:0]  level;
    logic [7:0]  rc, fc, dc;
    logic        ov;

    int errors = 0;
    int checks = 0;
    vec_t tbl[25];

    edge_event_tracker #(.TS_W(16), .DEPTH(4), .CNT_W(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en_i          (en),
        .sample_i      (smp),
        .sample_prev_i (smp_prev),
        .clr_i         (clr),
        .evt_valid_o   (valid),
        .evt_ready_i   (rdy),
        .evt_rise_o    (rise),
        .evt_ts_o      (ts),
        .level_o       (level),
        .rise_cnt_o    (rc),
        .fall_cnt_o    (fc),
        .drop_cnt_o    (dc),
        .overflow_o    (ov)
    );

    always #5 clk = ~clk;

    function automatic out_t o(int v, int r, int t, int l, int rcv, int fcv, int dcv, int ovv);
        out_t x;
        x.valid = 1'(v);
        x.rise  = 1'(r);
        x.ts    = 16'(t);
        x.level = 3'(l);
        x.rc    = 8'(rcv);
        x.fc    = 8'(fcv);
        x.dc    = 8'(dcv);
        x.ov    = 1'(ovv);
        return x;
    endfunction

    function automatic vec_t mk(logic e, logic s, logic p, logic c, logic r, out_t x);
        vec_t v;
        v.en = e; v.s = s; v.p = p; v.clr = c; v.rdy = r; v.exp = x;
        return v;
    endfunction

    task automatic drive(input logic e, input logic s, input logic p, input logic c, input logic r);
        en = e; smp = s; smp_prev = p; clr = c; rdy = r;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input out_t exp);
        out_t act;
        act.valid = valid; act.rise = rise; act.ts = ts; act.level = level;
        act.rc = rc; act.fc = fc; act.dc = dc; act.ov = ov;
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got valid=%b rise=%b ts=%h lvl=%0d rc=%0d fc=%0d dc=%0d ov=%b; want valid=%b rise=%b ts=%h lvl=%0d rc=%0d fc=%0d dc=%0d ov=%b",
                     name, act.valid, act.rise, act.ts, act.level, act.rc, act.fc, act.dc, act.ov,
                     exp.valid, exp.rise, exp.ts, exp.level, exp.rc, exp.fc, exp.dc, exp.ov);
        end
    endtask

    initial begin
        // Row k is applied in the cycle where ts==k while en stays high; expectations are post-edge.
        for (int i = 0; i < 5; i++) tbl[i] = mk(1, 0, 0, 0, 1, o(0, 0, 0, 0, 0, 0, 0, 0));
        tbl[5]  = mk(1, 1, 0, 0, 1, o(1, 1, 5, 1, 1, 0, 0, 0));
        tbl[6]  = mk(1, 1, 1, 0, 1, o(0, 0, 0, 0, 1, 0, 0, 0));
        for (int i = 7; i < 10; i++) tbl[i] = mk(1, 1, 1, 0, 0, o(0, 0, 0, 0, 1, 0, 0, 0));
        tbl[10] = mk(1, 0, 1, 0, 0, o(1, 0, 10, 1, 1, 1, 0, 0));
        tbl[11] = mk(1, 1, 0, 0, 0, o(1, 0, 10, 2, 2, 1, 0, 0));
        tbl[12] = mk(1, 0, 1, 0, 0, o(1, 0, 10, 3, 2, 2, 0, 0));
        tbl[13] = mk(1, 1, 0, 0, 0, o(1, 0, 10, 4, 3, 2, 0, 0));
        tbl[14] = mk(1, 0, 1, 0, 0, o(1, 0, 10, 4, 3, 3, 1, 1));
        tbl[15] = mk(1, 1, 0, 0, 1, o(1, 1, 11, 4, 4, 3, 1, 1));
        tbl[16] = mk(0, 1, 0, 0, 1, o(1, 0, 12, 3, 4, 3, 1, 1));
        tbl[17] = mk(0, 0, 1, 0, 1, o(1, 1, 13, 2, 4, 3, 1, 1));
        tbl[18] = mk(0, 1, 0, 0, 0, o(1, 1, 13, 2, 4, 3, 1, 1));
        tbl[19] = mk(0, 0, 1, 0, 1, o(1, 1, 15, 1, 4, 3, 1, 1));
        tbl[20] = mk(1, 1, 0, 0, 0, o(1, 1, 15, 2, 5, 3, 1, 1));
        tbl[21] = mk(1, 0, 1, 0, 0, o(1, 1, 15, 3, 5, 4, 1, 1));
        tbl[22] = mk(1, 1, 0, 1, 1, o(0, 0, 0, 0, 0, 0, 0, 0));
        tbl[23] = mk(1, 1, 0, 0, 0, o(1, 1, 0, 1, 1, 0, 0, 0));
        tbl[24] = mk(0, 0, 0, 0, 1, o(0, 0, 0, 0, 1, 0, 0, 0));

        rst_n = 1'b0;
        drive(1, 1, 0, 0, 1);
        tick();
        tick();
        check("reset", o(0, 0, 0, 0, 0, 0, 0, 0));
        rst_n = 1'b1;

        for (int i = 0; i < 25; i++) begin
            drive(tbl[i].en, tbl[i].s, tbl[i].p, tbl[i].clr, tbl[i].rdy);
            tick();
            check($sformatf("row%0d", i), tbl[i].exp);
        end

        // 300 rises interleaved with 100 falls; consumer always ready.
        drive(1, 0, 0, 1, 1);
        tick();
        check("clr_sat", o(0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 300; i++) begin
            drive(1, 1, 0, 0, 1);
            tick();
            if (i == 254) begin
                checks++;
                if (rc !== 8'd255) begin
                    errors++;
                    $display("FAIL rise_cnt_255: got %0d want 255", rc);
                end
            end
            if (i < 100) begin
                drive(1, 0, 1, 0, 1);
                tick();
            end
        end
        check("saturate", o(1, 1, 399, 1, 255, 100, 0, 0));

        // Timestamp wrap: edges at 0xFFFF and 0x0000.
        drive(1, 0, 0, 1, 0);
        tick();
        check("clr_wrap", o(0, 0, 0, 0, 0, 0, 0, 0));
        drive(1, 0, 0, 0, 0);
        repeat (65535) @(posedge clk);
        #1;
        drive(1, 1, 0, 0, 0);
        tick();
        check("wrap_ffff", o(1, 1, 16'hFFFF, 1, 1, 0, 0, 0));
        drive(1, 0, 1, 0, 0);
        tick();
        check("wrap_push0", o(1, 1, 16'hFFFF, 2, 1, 1, 0, 0));
        drive(0, 0, 0, 0, 1);
        tick();
        check("wrap_0000", o(1, 0, 0, 1, 1, 1, 0, 0));

        // Reset in the middle of activity.
        drive(1, 1, 0, 0, 0);
        tick();
        check("pre_rst", o(1, 0, 0, 2, 2, 1, 0, 0));
        rst_n = 1'b0;
        drive(1, 0, 1, 0, 1);
        tick();
        check("mid_rst", o(0, 0, 0, 0, 0, 0, 0, 0));
        rst_n = 1'b1;
        drive(1, 1, 0, 0, 0);
        tick();
        check("post_rst", o(1, 1, 0, 1, 1, 0, 0, 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
